// File: rtl/regfile.sv
// Y86 general-purpose register file: eight 32-bit registers, two writeback
// ports (E and M) and two combinational read ports with write-through bypass.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wb_dstE,
    input  logic [31:0] wb_valE,
    input  logic [7:0]  wb_dstM,
    input  logic [31:0] wb_valM,
    input  logic [7:0]  d_srcA,
    input  logic [7:0]  d_srcB,
    output logic [31:0] d_rvalA,
    output logic [31:0] d_rvalB
);

    localparam int unsigned NumRegs = 8;

    logic [31:0] regs_q [NumRegs];
    logic [31:0] regs_d [NumRegs];

    logic dst_e_valid;
    logic dst_m_valid;
    logic src_a_valid;
    logic src_b_valid;

    // An ID is valid only when the whole byte is 0-7; 8'h0F and any alias
    // whose low bits happen to hit a register must be ignored.
    assign dst_e_valid = (wb_dstE[7:3] == 5'd0);
    assign dst_m_valid = (wb_dstM[7:3] == 5'd0);
    assign src_a_valid = (d_srcA[7:3] == 5'd0);
    assign src_b_valid = (d_srcB[7:3] == 5'd0);

    // Next-state of the register array; M is applied last so it wins a collision.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (dst_e_valid) begin
            regs_d[wb_dstE[2:0]] = wb_valE;
        end
        if (dst_m_valid) begin
            regs_d[wb_dstM[2:0]] = wb_valM;
        end
    end

    // Storage: asynchronous clear, otherwise commit the writeback ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: M bypass over E bypass over storage; zero while in reset.
    always_comb begin
        d_rvalA = 32'h0;
        d_rvalB = 32'h0;
        if (rst && src_a_valid) begin
            if (dst_m_valid && (d_srcA == wb_dstM)) begin
                d_rvalA = wb_valM;
            end else if (dst_e_valid && (d_srcA == wb_dstE)) begin
                d_rvalA = wb_valE;
            end else begin
                d_rvalA = regs_q[d_srcA[2:0]];
            end
        end
        if (rst && src_b_valid) begin
            if (dst_m_valid && (d_srcB == wb_dstM)) begin
                d_rvalB = wb_valM;
            end else if (dst_e_valid && (d_srcB == wb_dstE)) begin
                d_rvalB = wb_valE;
            end else begin
                d_rvalB = regs_q[d_srcB[2:0]];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for the Y86 register file.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [7:0]  wb_dstE;
    logic [31:0] wb_valE;
    logic [7:0]  wb_dstM;
    logic [31:0] wb_valM;
    logic [7:0]  d_srcA;
    logic [7:0]  d_srcB;
    logic [31:0] d_rvalA;
    logic [31:0] d_rvalB;

    int errors;
    int checks;

    // Expected contents after the data-path tests, index = register ID.
    logic [31:0] exp_regs [8];

    regfile dut (
        .clk     (clk),
        .rst     (rst),
        .wb_dstE (wb_dstE),
        .wb_valE (wb_valE),
        .wb_dstM (wb_dstM),
        .wb_valM (wb_valM),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .d_rvalA (d_rvalA),
        .d_rvalB (d_rvalB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb();
        wb_dstE = 8'h0F;
        wb_dstM = 8'h0F;
        wb_valE = 32'h0;
        wb_valM = 32'h0;
    endtask

    task automatic test_reset();
        // Every register reads zero out of power-on reset.
        for (int i = 0; i < 8; i++) begin
            d_srcA = 8'(i);
            #1;
            checks++;
            if (d_rvalA !== 32'h0) begin
                errors++;
                $display("FAIL reset_init reg%0d: got %h want %h", i, d_rvalA, 32'h0);
            end
        end
        // Store 0x1234 in %ecx, then pulse reset with no clock edge.
        wb_dstE = 8'd1;
        wb_valE = 32'h1234;
        step();
        idle_wb();
        d_srcA = 8'd1;
        #1;
        checks++;
        if (d_rvalA !== 32'h1234) begin
            errors++;
            $display("FAIL reset_prewrite: got %h want %h", d_rvalA, 32'h1234);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (d_rvalA !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_clear: got %h want %h", d_rvalA, 32'h0);
        end
        // Bypass is suppressed while reset is low.
        wb_dstE = 8'd1;
        wb_valE = 32'h99;
        #1;
        checks++;
        if (d_rvalA !== 32'h0) begin
            errors++;
            $display("FAIL reset_bypass_blocked: got %h want %h", d_rvalA, 32'h0);
        end
        idle_wb();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (d_rvalA !== 32'h0) begin
            errors++;
            $display("FAIL reset_after_release: got %h want %h", d_rvalA, 32'h0);
        end
    endtask

    task automatic test_basic();
        // irmovl into %edx.
        wb_dstE = 8'd2;
        wb_valE = 32'hDEADBEEF;
        step();
        idle_wb();
        d_srcA = 8'd2;
        d_srcB = 8'd3;
        #1;
        checks++;
        if (d_rvalA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_read_a: got %h want %h", d_rvalA, 32'hDEADBEEF);
        end
        checks++;
        if (d_rvalB !== 32'h0) begin
            errors++;
            $display("FAIL basic_read_b: got %h want %h", d_rvalB, 32'h0);
        end
    endtask

    task automatic test_bypass();
        wb_dstE = 8'd5;
        wb_valE = 32'h55;
        d_srcA = 8'd5;
        d_srcB = 8'd5;
        #1;
        checks++;
        if (d_rvalA !== 32'h55) begin
            errors++;
            $display("FAIL bypass_same_cycle_a: got %h want %h", d_rvalA, 32'h55);
        end
        checks++;
        if (d_rvalB !== 32'h55) begin
            errors++;
            $display("FAIL bypass_same_cycle_b: got %h want %h", d_rvalB, 32'h55);
        end
        step();
        idle_wb();
        #1;
        checks++;
        if (d_rvalA !== 32'h55) begin
            errors++;
            $display("FAIL bypass_stored: got %h want %h", d_rvalA, 32'h55);
        end
    endtask

    task automatic test_collision();
        // popl %esp: M wins over E for the same destination.
        wb_dstE = 8'd4;
        wb_valE = 32'h104;
        wb_dstM = 8'd4;
        wb_valM = 32'hABCD;
        d_srcA = 8'd4;
        #1;
        checks++;
        if (d_rvalA !== 32'hABCD) begin
            errors++;
            $display("FAIL collision_bypass: got %h want %h", d_rvalA, 32'hABCD);
        end
        step();
        idle_wb();
        #1;
        checks++;
        if (d_rvalA !== 32'hABCD) begin
            errors++;
            $display("FAIL collision_stored: got %h want %h", d_rvalA, 32'hABCD);
        end
    endtask

    task automatic test_dual_write();
        wb_dstE = 8'd4;
        wb_valE = 32'hFC;
        wb_dstM = 8'd0;
        wb_valM = 32'h7;
        d_srcA = 8'd4;
        d_srcB = 8'd0;
        #1;
        checks++;
        if (d_rvalA !== 32'hFC) begin
            errors++;
            $display("FAIL dual_bypass_e: got %h want %h", d_rvalA, 32'hFC);
        end
        checks++;
        if (d_rvalB !== 32'h7) begin
            errors++;
            $display("FAIL dual_bypass_m: got %h want %h", d_rvalB, 32'h7);
        end
        step();
        idle_wb();
        #1;
        checks++;
        if (d_rvalA !== 32'hFC) begin
            errors++;
            $display("FAIL dual_stored_e: got %h want %h", d_rvalA, 32'hFC);
        end
        checks++;
        if (d_rvalB !== 32'h7) begin
            errors++;
            $display("FAIL dual_stored_m: got %h want %h", d_rvalB, 32'h7);
        end
    endtask

    task automatic test_invalid_ids();
        exp_regs[0] = 32'h7;
        exp_regs[1] = 32'h0;
        exp_regs[2] = 32'hDEADBEEF;
        exp_regs[3] = 32'h0;
        exp_regs[4] = 32'hFC;
        exp_regs[5] = 32'h55;
        exp_regs[6] = 32'h0;
        exp_regs[7] = 32'h0;
        wb_dstE = 8'h0F;
        wb_valE = 32'hFFFF_FFFF;
        wb_dstM = 8'h09;
        wb_valM = 32'hFFFF_FFFF;
        step();
        step();
        // Out-of-range IDs whose low bits alias real registers.
        wb_dstE = 8'h0C;
        wb_dstM = 8'h10;
        d_srcA = 8'h0C;
        #1;
        checks++;
        if (d_rvalA !== 32'h0) begin
            errors++;
            $display("FAIL invalid_bypass: got %h want %h", d_rvalA, 32'h0);
        end
        step();
        idle_wb();
        // Non-clocked input wiggle must not touch storage.
        wb_valE = 32'h1111_1111;
        wb_valM = 32'h2222_2222;
        #2;
        wb_valE = 32'h0;
        wb_valM = 32'h0;
        #1;
        for (int i = 0; i < 8; i++) begin
            d_srcA = 8'(i);
            d_srcB = 8'(7 - i);
            #1;
            checks++;
            if (d_rvalA !== exp_regs[i]) begin
                errors++;
                $display("FAIL invalid_unchanged reg%0d: got %h want %h", i, d_rvalA, exp_regs[i]);
            end
            checks++;
            if (d_rvalB !== exp_regs[7 - i]) begin
                errors++;
                $display("FAIL invalid_unchanged_b reg%0d: got %h want %h", 7 - i, d_rvalB,
                         exp_regs[7 - i]);
            end
        end
        d_srcA = 8'h0F;
        d_srcB = 8'h08;
        #1;
        checks++;
        if (d_rvalA !== 32'h0) begin
            errors++;
            $display("FAIL invalid_read_0f: got %h want %h", d_rvalA, 32'h0);
        end
        checks++;
        if (d_rvalB !== 32'h0) begin
            errors++;
            $display("FAIL invalid_read_08: got %h want %h", d_rvalB, 32'h0);
        end
        d_srcA = 8'h10;
        d_srcB = 8'h0D;
        #1;
        checks++;
        if (d_rvalA !== 32'h0) begin
            errors++;
            $display("FAIL invalid_read_10: got %h want %h", d_rvalA, 32'h0);
        end
        checks++;
        if (d_rvalB !== 32'h0) begin
            errors++;
            $display("FAIL invalid_read_0d: got %h want %h", d_rvalB, 32'h0);
        end
    endtask

    task automatic test_reset_mid_op();
        // Reset held across an edge with a write presented: write is lost.
        wb_dstE = 8'd2;
        wb_valE = 32'hCAFE;
        wb_dstM = 8'd6;
        wb_valM = 32'hBEEF;
        rst = 1'b0;
        step();
        idle_wb();
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            d_srcA = 8'(i);
            #1;
            checks++;
            if (d_rvalA !== 32'h0) begin
                errors++;
                $display("FAIL midreset_clear reg%0d: got %h want %h", i, d_rvalA, 32'h0);
            end
        end
        // First edge after release commits.
        wb_dstM = 8'd7;
        wb_valM = 32'h7777;
        step();
        idle_wb();
        d_srcA = 8'd7;
        d_srcB = 8'd2;
        #1;
        checks++;
        if (d_rvalA !== 32'h7777) begin
            errors++;
            $display("FAIL midreset_first_write: got %h want %h", d_rvalA, 32'h7777);
        end
        checks++;
        if (d_rvalB !== 32'h0) begin
            errors++;
            $display("FAIL midreset_lost_write: got %h want %h", d_rvalB, 32'h0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        idle_wb();
        d_srcA = 8'h0F;
        d_srcB = 8'h0F;
        #12;
        rst = 1'b1;
        step();
        test_reset();
        test_basic();
        test_bypass();
        test_collision();
        test_dual_write();
        test_invalid_ids();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Y86 general-purpose register file: eight 32-bit registers, written by the writeback stage and read by the decode stage. It consumes the writeback port pair (dstE/valE, dstM/valM) that the MEM/WB stage drives, and serves two read ports (srcA, srcB). Writes commit on the rising clock edge. Reads are combinational with write-through bypass, so a value written this cycle is visible to decode in the same cycle.

## Interface
- No parameters. Widths come from `defines.v`: `WORD` = 32 bits, `BYTE` = 8 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_dstE  input  `BYTE`  E-port destination register ID; 0–7 valid, 4'hF (8'h0F) = none.
- wb_valE  input  `WORD`  E-port write data.
- wb_dstM  input  `BYTE`  M-port destination register ID; 0–7 valid, 4'hF = none.
- wb_valM  input  `WORD`  M-port write data.
- d_srcA  input  `BYTE`  read port A register ID; 4'hF = none.
- d_srcB  input  `BYTE`  read port B register ID; 4'hF = none.
- d_rvalA  output  `WORD`  read port A data.
- d_rvalB  output  `WORD`  read port B data.

## Operation
- Register map: 0 %eax, 1 %ecx, 2 %edx, 3 %ebx, 4 %esp, 5 %ebp, 6 %esi, 7 %edi.
- ID decode: an ID is valid only when the full `BYTE` value is 0–7. Any other value, including 8'h0F, means no write or no read.
- Write E: if wb_dstE is valid, reg[wb_dstE] <= wb_valE at the rising edge.
- Write M: if wb_dstM is valid, reg[wb_dstM] <= wb_valM at the rising edge.
- Collision: if wb_dstE == wb_dstM and both are valid, wb_valM is written and wb_valE is discarded. This covers popl %esp.
- Read: d_rvalX equals the effective next value of reg[d_srcX]. Priority, highest first:
  - wb_valM, if d_srcX == wb_dstM and the ID is valid;
  - else wb_valE, if d_srcX == wb_dstE and the ID is valid;
  - else the stored reg[d_srcX].
- Invalid read ID: d_rvalX = 32'h0000_0000.
- Both read ports are independent. They may address the same register and then return identical data.
- No other state exists and there is no write enable. Writeback bubbles arrive as dst = 4'hF.

## Timing
- Reset:
  - rst low immediately clears all eight registers to 32'h0, with no clock required.
  - While rst is low, writes are blocked and reads return 0 (the bypass is also suppressed).
- Reset release: the first write commits on the first rising edge with rst high.
- Reset mid-operation: asserting rst clears all registers asynchronously, and any write presented in that cycle is lost.
- Write latency: one edge into storage. Read latency: zero (combinational), including the bypass path.
- Read outputs settle within the same cycle as any change to srcA, srcB, dst or val. Decode may sample them at the next edge.
- Storage is only modified on the rising edge or by reset. Input changes between edges never alter stored values.

## Test plan
- Reset: write 32'h1234 to %ecx, then pulse rst low for half a cycle with no clock edge -> d_rvalA = 0 for srcA = 1 immediately and after release.
- Basic write/read (irmovl): dstE = 2, valE = 32'hDEADBEEF, one edge, then dstE = F; srcA = 2 -> 32'hDEADBEEF; srcB = 3 -> 0.
- Same-cycle bypass: dstE = 5, valE = 32'h55 with srcA = 5 before the edge -> d_rvalA = 32'h55 in the same cycle; stored value is 32'h55 after the edge.
- E/M collision (popl %esp): dstE = 4, valE = 32'h104, dstM = 4, valM = 32'hABCD -> d_rvalA = 32'hABCD before the edge; after the edge, reg 4 = 32'hABCD.
- Dual write, distinct registers: dstE = 4, valE = 32'hFC, dstM = 0, valM = 32'h7 -> after one edge, srcA = 4 gives 32'hFC and srcB = 0 gives 32'h7.
- Invalid IDs: dstE = 8'h0F, valE = 32'hFFFF_FFFF and dstM = 8'h09 for several edges -> all registers unchanged; srcA = 8'h0F gives 0.
